// File: rtl/parallel_to_serial_pkg.sv
// Shared definitions for the parallel-to-serial transmitter:
// FSM state encodings and the default word width.
package parallel_to_serial_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/tx_hold_reg.sv
// One-entry hold buffer between the upstream handshake and the shifter.
module tx_hold_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr,
    input  logic [DATA_W-1:0] din,
    input  logic              rd,
    output logic [DATA_W-1:0] dout,
    output logic              full
);

    // wr is only issued while empty and rd only while full, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            dout <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (wr) begin
            dout <= din;
            full <= 1'b1;
        end else if (rd) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/parallel_to_serial.sv
// Serialises DATA_W-bit words MSB first, gated by Enable, with a one-entry
// hold buffer so the next word can be accepted while the current one shifts.
module parallel_to_serial
    import parallel_to_serial_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Enable,
    input  logic              abort,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              serial_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t              state, state_n;
    logic [DATA_W-1:0]   shreg, shreg_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                sout_n;

    logic                hold_full;
    logic [DATA_W-1:0]   hold_dout;
    logic                hold_wr;
    logic                load;

    assign tx_ready = ~hold_full;
    assign hold_wr  = tx_valid & tx_ready & ~abort;
    assign load     = hold_full & Enable & ~abort & ((state == IDLE) || (state == DONE));

    tx_hold_reg #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (abort),
        .wr    (hold_wr),
        .din   (tx_data),
        .rd    (load),
        .dout  (hold_dout),
        .full  (hold_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            serial_out <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            cnt        <= cnt_n;
            serial_out <= sout_n;
        end
    end

    // The shift register moves left so the next bit always sits at DATA_W-2.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        sout_n  = serial_out;

        if (abort) begin
            state_n = IDLE;
            shreg_n = '0;
            cnt_n   = '0;
            sout_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sout_n = 1'b0;
                    if (load) begin
                        state_n = SHIFT;
                        shreg_n = hold_dout;
                        cnt_n   = CNT_W'(DATA_W - 1);
                        sout_n  = hold_dout[DATA_W-1];
                    end
                end
                SHIFT: begin
                    if (Enable) begin
                        if (cnt != '0) begin
                            shreg_n = shreg << 1;
                            cnt_n   = cnt - 1'b1;
                            sout_n  = shreg[DATA_W-2];
                        end else begin
                            state_n = DONE;
                            sout_n  = 1'b0;
                        end
                    end
                end
                DONE: begin
                    sout_n  = 1'b0;
                    state_n = IDLE;
                    if (load) begin
                        state_n = SHIFT;
                        shreg_n = hold_dout;
                        cnt_n   = CNT_W'(DATA_W - 1);
                        sout_n  = hold_dout[DATA_W-1];
                    end
                end
                default: begin
                    state_n = IDLE;
                    sout_n  = 1'b0;
                end
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule
